// File: rtl/present_key_schedule.sv
// PRESENT-80 round-key generator.
// Holds the 80-bit key state and presents round key Ki = key_state[79:16].
// Each `next` request in ACTIVE applies one key-schedule round. The schedule
// finishes in DONE once K(ROUNDS+1) is on the output.
// Optional feature macro: KS_STATE_OUT_EN. When it is defined, the block adds
// the key_state_out port, which exposes the raw 80-bit key state.
module present_key_schedule #(
    parameter int ROUNDS = 31,
    parameter int CNT_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [79:0]      key_in,
    input  logic             load,
    input  logic             next,
    output logic [63:0]      round_key,
    output logic             round_key_valid,
    output logic [CNT_W-1:0] round_cnt,
    output logic             done
`ifdef KS_STATE_OUT_EN
    ,
    output logic [79:0]      key_state_out
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Round index carried by the final key; reaching it ends the schedule.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROUNDS + 1);

    // PRESENT 4-bit S-box.
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0:    y = 4'hC;
            4'h1:    y = 4'h5;
            4'h2:    y = 4'h6;
            4'h3:    y = 4'hB;
            4'h4:    y = 4'h9;
            4'h5:    y = 4'h0;
            4'h6:    y = 4'hA;
            4'h7:    y = 4'hD;
            4'h8:    y = 4'h3;
            4'h9:    y = 4'hE;
            4'hA:    y = 4'hF;
            4'hB:    y = 4'h8;
            4'hC:    y = 4'h4;
            4'hD:    y = 4'h7;
            4'hE:    y = 4'h1;
            4'hF:    y = 4'h2;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    // One key-schedule round. The state is rotated left by 61 bits, the top
    // nibble is passed through the S-box, and the round index is XORed in.
    function automatic logic [79:0] key_update(input logic [79:0] k, input logic [4:0] i);
        logic [79:0] r;
        r          = {k[18:0], k[79:19]};
        r[79:76]   = sbox(r[79:76]);
        r[19:15]   = r[19:15] ^ i;
        return r;
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [79:0]      key_state_r;
    logic [79:0]      key_state_s;
    logic [CNT_W-1:0] round_cnt_r;
    logic [CNT_W-1:0] round_cnt_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             valid_r;
    logic             valid_s;
    logic             done_r;
    logic             done_s;

    // Next-state logic. A load restarts the schedule from any state and takes
    // priority over next. Next only advances the schedule while ACTIVE.
    always_comb begin
        state_s     = state_r;
        key_state_s = key_state_r;
        round_cnt_s = round_cnt_r;
        cnt_inc_s   = round_cnt_r + CNT_W'(1);
        if (load) begin
            key_state_s = key_in;
            round_cnt_s = CNT_W'(1);
            state_s     = ACTIVE;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                ACTIVE: begin
                    if (next) begin
                        key_state_s = key_update(key_state_r, round_cnt_r[4:0]);
                        round_cnt_s = cnt_inc_s;
                        if (cnt_inc_s == LAST_CNT) begin
                            state_s = DONE;
                        end else begin
                            state_s = ACTIVE;
                        end
                    end else begin
                        state_s = ACTIVE;
                    end
                end
                DONE: begin
                    state_s = DONE;
                end
                default: begin
                    // An illegal encoding falls back to idle, and the counter is cleared.
                    state_s     = IDLE;
                    round_cnt_s = '0;
                end
            endcase
        end
        valid_s = (state_s != IDLE);
        done_s  = (state_s == DONE);
    end

    // State and output registers. Reset has the highest priority and aborts any schedule in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            key_state_r <= 80'h0;
            round_cnt_r <= '0;
            valid_r     <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            key_state_r <= key_state_s;
            round_cnt_r <= round_cnt_s;
            valid_r     <= valid_s;
            done_r      <= done_s;
        end
    end

    assign round_key       = key_state_r[79:16];
    assign round_key_valid = valid_r;
    assign round_cnt       = round_cnt_r;
    assign done            = done_r;

`ifdef KS_STATE_OUT_EN
    assign key_state_out = key_state_r;
`endif

endmodule

// File: tb/tb_present_key_schedule.sv
// Self-checking bench for present_key_schedule.
// A behavioural model tracks the expected key and round index. A checker
// compares every DUT output with the model on each falling edge.
// Literal checks pin the model, including a full PRESENT-80 encryption vector.
module tb_present_key_schedule;

    localparam int ROUNDS = 31;
    localparam int CNT_W  = 6;

    logic             clk;
    logic             rst;
    logic [79:0]      key_in;
    logic             load;
    logic             next;
    logic [63:0]      round_key;
    logic             round_key_valid;
    logic [CNT_W-1:0] round_cnt;
    logic             done;
`ifdef KS_STATE_OUT_EN
    logic [79:0]      key_state_out;
`endif

    int total = 0;
    int bad   = 0;

    // Model state: the expected key state and round index (0 = idle).
    logic [79:0] m_key;
    int          m_idx;

    logic [63:0] rk_cap [1:32];

    present_key_schedule #(.ROUNDS(ROUNDS), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .key_in          (key_in),
        .load            (load),
        .next            (next),
        .round_key       (round_key),
        .round_key_valid (round_key_valid),
        .round_cnt       (round_cnt),
        .done            (done)
`ifdef KS_STATE_OUT_EN
        ,
        .key_state_out   (key_state_out)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] sb(input logic [3:0] x);
        logic [63:0] tbl;
        tbl = 64'h21748FE3DA09B65C;
        return tbl[x*4 +: 4];
    endfunction

    // Reference key-schedule round, written with plain shifts.
    function automatic logic [79:0] ks_next(input logic [79:0] k, input int i);
        logic [79:0] r;
        logic [79:0] rc;
        r        = (k << 61) | (k >> 19);
        r[79:76] = sb(r[79:76]);
        rc       = 80'(i & 31);
        return r ^ (rc << 15);
    endfunction

    // PRESENT encryption using the captured round keys.
    function automatic logic [63:0] encrypt(input logic [63:0] pt);
        logic [63:0] s;
        logic [63:0] t;
        s = pt;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ rk_cap[r];
            for (int n = 0; n < 16; n++) t[n*4 +: 4] = sb(s[n*4 +: 4]);
            for (int b = 0; b < 64; b++) s[(b == 63) ? 63 : ((b * 16) % 63)] = t[b];
        end
        return s ^ rk_cap[32];
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model, updated from the inputs sampled at each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            m_key <= 80'h0;
            m_idx <= 0;
        end else if (load) begin
            m_key <= key_in;
            m_idx <= 1;
        end else if (next && m_idx >= 1 && m_idx <= ROUNDS) begin
            m_key <= ks_next(m_key, m_idx);
            m_idx <= m_idx + 1;
        end
    end

    // Compare all DUT outputs with the model on every falling edge.
    always @(negedge clk) begin
        chk("round_key", {16'h0, round_key}, {16'h0, m_key[79:16]});
        chk("valid", {79'h0, round_key_valid}, {79'h0, (m_idx != 0)});
        chk("round_cnt", {74'h0, round_cnt}, 80'(m_idx));
        chk("done", {79'h0, done}, {79'h0, (m_idx == ROUNDS + 1)});
`ifdef KS_STATE_OUT_EN
        chk("key_state_out", key_state_out, m_key);
`endif
    end

    // Apply one cycle of inputs and return at the next falling edge.
    task automatic step(input logic l, input logic n, input logic r, input logic [79:0] k);
        load   = l;
        next   = n;
        rst    = r;
        key_in = k;
        @(negedge clk);
    endtask

    function automatic logic [79:0] rand_key();
        return {16'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    logic [79:0] ones;
    logic [63:0] held;

    initial begin
        ones = {80{1'b1}};
        // Reset with load and next held active.
        step(1'b1, 1'b1, 1'b1, rand_key());
        step(1'b1, 1'b1, 1'b1, rand_key());
        chk("reset_rk", {16'h0, round_key}, 80'h0);
        chk("reset_valid", {79'h0, round_key_valid}, 80'h0);
        chk("reset_cnt", {74'h0, round_cnt}, 80'h0);
        step(1'b0, 1'b1, 1'b0, 80'h0);
        chk("idle_next_cnt", {74'h0, round_cnt}, 80'h0);

        // Zero key.
        step(1'b1, 1'b0, 1'b0, 80'h0);
        chk("zero_k1", {16'h0, round_key}, 80'h0);
        chk("zero_cnt1", {74'h0, round_cnt}, 80'd1);
        step(1'b0, 1'b1, 1'b0, 80'h0);
        chk("zero_k2", {16'h0, round_key}, {16'h0, 64'hC000000000000000});
        chk("zero_cnt2", {74'h0, round_cnt}, 80'd2);

        // All-ones key.
        step(1'b1, 1'b0, 1'b0, ones);
        chk("ones_k1", {16'h0, round_key}, {16'h0, 64'hFFFFFFFFFFFFFFFF});
        step(1'b0, 1'b1, 1'b0, 80'h0);
        chk("ones_k2", {16'h0, round_key}, {16'h0, 64'h2FFFFFFFFFFFFFFF});

        // Full schedule with next held high, followed by encryption of plaintext 0.
        step(1'b1, 1'b0, 1'b0, 80'h0);
        rk_cap[1] = round_key;
        for (int i = 2; i <= 32; i++) begin
            step(1'b0, 1'b1, 1'b0, 80'h0);
            rk_cap[i] = round_key;
        end
        chk("full_cnt", {74'h0, round_cnt}, 80'd32);
        chk("full_done", {79'h0, done}, 80'd1);
        chk("encrypt", {16'h0, encrypt(64'h0)}, {16'h0, 64'h5579C1387B228445});
        held = round_key;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 80'h0);
        chk("done_hold", {16'h0, round_key}, {16'h0, held});

        // Load takes priority over next at round 10.
        step(1'b1, 1'b0, 1'b0, rand_key());
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 80'h0);
        chk("pre_prio_cnt", {74'h0, round_cnt}, 80'd10);
        step(1'b1, 1'b1, 1'b0, ones);
        chk("prio_rk", {16'h0, round_key}, {16'h0, 64'hFFFFFFFFFFFFFFFF});
        chk("prio_cnt", {74'h0, round_cnt}, 80'd1);
        chk("prio_done", {79'h0, done}, 80'h0);

        // Reset in the middle of the schedule.
        step(1'b1, 1'b0, 1'b0, rand_key());
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 80'h0);
        chk("pre_rst_cnt", {74'h0, round_cnt}, 80'd5);
        step(1'b0, 1'b1, 1'b1, 80'h0);
        chk("midrst_rk", {16'h0, round_key}, 80'h0);
        chk("midrst_cnt", {74'h0, round_cnt}, 80'h0);
        step(1'b0, 1'b1, 1'b0, 80'h0);
        chk("midrst_next_valid", {79'h0, round_key_valid}, 80'h0);
        chk("midrst_next_rk", {16'h0, round_key}, 80'h0);

        // Random traffic, checked by the model on every cycle.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 63) == 0), rand_key());
        end
        step(1'b0, 1'b0, 1'b0, 80'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
